// File: rtl/image_pkg.sv
// Shared pixel-stream definitions: pixel width, default frame size, slot
// encoding of the three-pixel packed word and a pixel extraction helper.
package image_pkg;

  localparam int PIX_W          = 8;
  localparam int DEF_IMG_WIDTH  = 256;
  localparam int DEF_IMG_HEIGHT = 256;

  localparam logic [1:0] SLOT_OLD = 2'd0;
  localparam logic [1:0] SLOT_MID = 2'd1;
  localparam logic [1:0] SLOT_NEW = 2'd2;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} unpack_state_t;

  // Slot 0 is the oldest pixel and sits in the top byte of the word.
  function automatic logic [PIX_W-1:0] word_pixel(input logic [3*PIX_W-1:0] word,
                                                  input logic [1:0]         k);
    logic [PIX_W-1:0] p;
    case (k)
      SLOT_OLD: p = word[3*PIX_W-1 -: PIX_W];
      SLOT_MID: p = word[2*PIX_W-1 -: PIX_W];
      default:  p = word[PIX_W-1:0];
    endcase
    return p;
  endfunction

endpackage

// File: rtl/raster_position_counter.sv
// Column/row raster position with start-of-frame, end-of-line, end-of-frame decode.
// Zero latency decode of registered counters; advances only when en is high.
module raster_position_counter #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          at_sof,
  output logic          at_eol,
  output logic          at_eof
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_comb begin
    at_sof = (col == '0) && (row == '0);
    at_eol = (col == COL_LAST);
    at_eof = at_eol && (row == ROW_LAST);
  end

endmodule

// File: rtl/window_unpacker.sv
// Re-serialises 3-pixel words into a raster pixel stream, oldest pixel first; first pixel one cycle after accept.
// Holds one word; in_ready reopens combinationally when the last slot is being consumed, giving zero-bubble reload.
module window_unpacker #(
  parameter int IMG_WIDTH  = image_pkg::DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = image_pkg::DEF_IMG_HEIGHT,
  parameter int PIX_W      = image_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3*PIX_W-1:0] three_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [PIX_W-1:0]   pixel_out,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic               pix_eof
);

  import image_pkg::SLOT_OLD;
  import image_pkg::SLOT_MID;
  import image_pkg::SLOT_NEW;
  import image_pkg::unpack_state_t;
  import image_pkg::ST_EMPTY;
  import image_pkg::ST_FULL;

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  unpack_state_t        state;
  logic [1:0]           slot;
  logic [3*PIX_W-1:0]   hold;
  logic                 accept;
  logic                 consume;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic                 at_sof;
  logic                 at_eol;
  logic                 at_eof;

  assign pix_valid = (state == ST_FULL);
  assign in_ready  = (state == ST_EMPTY) || ((slot == SLOT_NEW) && pix_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = pix_valid && pix_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
      slot  <= SLOT_OLD;
      hold  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            hold  <= three_in;
            slot  <= SLOT_OLD;
            state <= ST_FULL;
          end
        end
        default: begin
          if (consume) begin
            if (slot != SLOT_NEW) begin
              slot <= slot + 2'd1;
            end else if (accept) begin
              hold <= three_in;
              slot <= SLOT_OLD;
            end else begin
              state <= ST_EMPTY;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    case (slot)
      SLOT_OLD: pixel_out = hold[3*PIX_W-1 -: PIX_W];
      SLOT_MID: pixel_out = hold[2*PIX_W-1 -: PIX_W];
      default:  pixel_out = hold[PIX_W-1:0];
    endcase
  end

  raster_position_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_pos (
    .clk   (clk),
    .reset (reset),
    .en    (consume),
    .col   (col),
    .row   (row),
    .at_sof(at_sof),
    .at_eol(at_eol),
    .at_eof(at_eof)
  );

  // Position flags describe the pixel on the bus, so they vanish when nothing is held.
  assign pix_sof = pix_valid && at_sof;
  assign pix_eol = pix_valid && at_eol;
  assign pix_eof = pix_valid && at_eof;

endmodule
